// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR message encryptor.
// Holds the maximal-length tap table, padding/clamp limits and the engine state encoding.
package lfsr_pkg;

    localparam logic [6:0] LFSR_PTRN [9] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };

    localparam logic [7:0] SPACE   = 8'h20;
    localparam logic [4:0] PRE_MIN = 5'd10;
    localparam logic [4:0] PRE_MAX = 5'd26;
    localparam logic [5:0] MSG_MAX = 6'd52;
    localparam int         IDX_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EMIT,
        DONE
    } state_t;

    typedef struct packed {
        logic [6:0] tap;
        logic [4:0] pre;
        logic [5:0] len;
    } run_cfg_t;

    function automatic logic [4:0] clamp_pre(input logic [4:0] p);
        if (p < PRE_MIN) return PRE_MIN;
        if (p > PRE_MAX) return PRE_MAX;
        return p;
    endfunction

    function automatic logic [5:0] clamp_msg(input logic [5:0] l);
        return (l > MSG_MAX) ? MSG_MAX : l;
    endfunction

    // Byte i comes from memory when it falls inside [pre, pre+len).
    function automatic logic in_window(input logic [IDX_W-1:0] i,
                                       input logic [4:0]       pre,
                                       input logic [5:0]       len);
        logic [IDX_W-1:0] lo;
        logic [IDX_W-1:0] hi;
        lo = {3'b000, pre};
        hi = lo + {2'b00, len};
        return (i >= lo) && (i < hi);
    endfunction

    // Key XOR on the low seven bits, even parity of the result placed in bit 7.
    function automatic logic [7:0] encrypt(input logic [6:0] p, input logic [6:0] key);
        logic [6:0] c;
        c = p ^ key;
        return {^c, c};
    endfunction

endpackage

// File: rtl/lfsr7.sv
// Seven-bit Fibonacci LFSR: left shift with XOR-of-taps feedback into bit 0.
// A zero seed is replaced by 0x01 so the register can never lock up at all-zeros.
module lfsr7 (
    input  logic       clk,
    input  logic       init,
    input  logic       load,
    input  logic       step,
    input  logic [6:0] seed,
    input  logic [6:0] tap,
    output logic [6:0] value
);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // in the design samples pre-edge values and the evaluation order cannot matter.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            value <= 7'h01;
        end else if (load) begin
            value <= (seed == 7'h00) ? 7'h01 : seed;
        end else if (step) begin
            value <= {value[5:0], ^(value & tap)};
        end
    end

endmodule

// File: rtl/lfsr_encryptor.sv
// Program 1 encryption engine: pads plaintext with spaces, XORs with an LFSR stream, adds parity.
// Optional macro ERR_INJECT_EN adds inj_en/inj_idx/inj_bit to corrupt one emitted bit.
module lfsr_encryptor
    import lfsr_pkg::*;
#(
    parameter int MSG_BASE = 0,
    parameter int OUT_BASE = 64,
    parameter int OUT_LEN  = 64,
    parameter int AW       = 8
) (
    input  logic          clk,
    input  logic          init,
    input  logic          req,
    output logic          ack,
    output logic          busy,
    input  logic [6:0]    tap_ptrn,
    input  logic [6:0]    seed,
    input  logic [4:0]    pre_len,
    input  logic [5:0]    msg_len,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_wr_addr,
    output logic [7:0]    mem_wr_data
`ifdef ERR_INJECT_EN
    ,
    input  logic          inj_en,
    input  logic [5:0]    inj_idx,
    input  logic [2:0]    inj_bit
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_LEN - 1);

    state_t           state;
    logic             armed;
    run_cfg_t         cfg;
    logic [IDX_W-1:0] idx;
    logic             use_mem;
    logic [6:0]       key;
    logic             lfsr_load;
    logic             lfsr_step;
    logic             start;
    logic [4:0]       pre_c;
    logic [5:0]       len_c;
    logic [IDX_W-1:0] next_idx;
    logic [6:0]       plain;
    logic [7:0]       cipher;
    logic             unused_rd_msb;

    function automatic logic [AW-1:0] rd_addr(input logic [IDX_W-1:0] i, input logic [4:0] pre);
        return AW'(MSG_BASE) + AW'(i) - AW'(pre);
    endfunction

    assign start     = (state == IDLE) && armed && !req;
    assign lfsr_load = start;
    assign lfsr_step = (state == EMIT);
    assign pre_c     = clamp_pre(pre_len);
    assign len_c     = clamp_msg(msg_len);
    assign next_idx  = idx + IDX_W'(1);

    // Plaintext bit 7 is deliberately discarded; parity overwrites that position.
    assign unused_rd_msb = mem_rd_data[7];

    lfsr7 u_lfsr (
        .clk   (clk),
        .init  (init),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .seed  (seed),
        .tap   (cfg.tap),
        .value (key)
    );

    // NOTE: every variable assigned here gets a value on every path first,
    // otherwise synthesis would infer a latch to hold it.
    always_comb begin
        plain  = use_mem ? mem_rd_data[6:0] : SPACE[6:0];
        cipher = encrypt(plain, key);
`ifdef ERR_INJECT_EN
        if (inj_en && (idx == {2'b00, inj_idx})) begin
            cipher = cipher ^ (8'h01 << inj_bit);
        end
`endif
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state       <= IDLE;
            armed       <= 1'b0;
            ack         <= 1'b0;
            busy        <= 1'b0;
            cfg         <= '0;
            idx         <= '0;
            use_mem     <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else begin
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        armed       <= 1'b0;
                        cfg         <= '{tap: tap_ptrn, pre: pre_c, len: len_c};
                        idx         <= '0;
                        busy        <= 1'b1;
                        ack         <= 1'b0;
                        mem_rd_en   <= in_window('0, pre_c, len_c);
                        mem_rd_addr <= rd_addr('0, pre_c);
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    // Read data lands during EMIT; remember whether this byte was read.
                    use_mem <= mem_rd_en;
                    state   <= EMIT;
                end
                EMIT: begin
                    mem_wr_en   <= 1'b1;
                    mem_wr_addr <= AW'(OUT_BASE) + AW'(idx);
                    mem_wr_data <= cipher;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        idx         <= next_idx;
                        mem_rd_en   <= in_window(next_idx, cfg.pre, cfg.len);
                        mem_rd_addr <= rd_addr(next_idx, cfg.pre);
                        state       <= FETCH;
                    end
                end
                DONE: begin
                    if (!ack) begin
                        ack  <= 1'b1;
                        busy <= 1'b0;
                    end else if (req) begin
                        ack   <= 1'b0;
                        armed <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_encryptor.sv
// Self-checking bench for lfsr_encryptor: vector table of run configurations plus
// hand-written abort, restart and (with ERR_INJECT_EN) error-injection sequences.
module tb_lfsr_encryptor;
    import lfsr_pkg::*;

    localparam int OUT_BASE = 64;
    localparam int OUT_LEN  = 64;
    localparam int ACK_EDGE = 2 * OUT_LEN + 1;
    localparam int RUN_EDGES = ACK_EDGE + 10;

    logic       clk = 1'b0;
    logic       init;
    logic       req;
    logic       ack;
    logic       busy;
    logic [6:0] tap_ptrn;
    logic [6:0] seed;
    logic [4:0] pre_len;
    logic [5:0] msg_len;
    logic       mem_rd_en;
    logic [7:0] mem_rd_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_addr;
    logic [7:0] mem_wr_data;
`ifdef ERR_INJECT_EN
    logic       inj_en;
    logic [5:0] inj_idx;
    logic [2:0] inj_bit;
`endif

    lfsr_encryptor dut (
        .clk         (clk),
        .init        (init),
        .req         (req),
        .ack         (ack),
        .busy        (busy),
        .tap_ptrn    (tap_ptrn),
        .seed        (seed),
        .pre_len     (pre_len),
        .msg_len     (msg_len),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data)
`ifdef ERR_INJECT_EN
        ,
        .inj_en      (inj_en),
        .inj_idx     (inj_idx),
        .inj_bit     (inj_bit)
`endif
    );

    always #5 clk = ~clk;

    // Plaintext region; read data appears the cycle after the strobe.
    logic [7:0] msg_mem [64];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= (mem_rd_addr < 8'd64) ? msg_mem[mem_rd_addr[5:0]] : 8'h00;
    end

    int n_vec = 0;
    int n_bad = 0;

    // Results of the most recent capture.
    logic [7:0] got [OUT_LEN];
    logic [7:0] exp_out [OUT_LEN];
    int wr_cnt, rd_cnt, first_rd, first_rd_addr, ack_edge, stray, wr_after;
    logic busy_start, ack_start, ack_end, busy_end;

    typedef struct {
        logic [6:0] tap;
        logic [6:0] seed;
        logic [4:0] pre;
        logic [5:0] len;
        int         first_rd;
        int         rd_cnt;
        logic [7:0] b0;
        logic [7:0] b6;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_vec++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got_v, exp_v);
        end
    endtask

    task automatic start_run(input logic [6:0] t, input logic [6:0] s,
                             input logic [4:0] p, input logic [5:0] l);
        tap_ptrn = t;
        seed     = s;
        pre_len  = p;
        msg_len  = l;
        req      = 1'b1;
        repeat (2) @(posedge clk);
        #1 req = 1'b0;
    endtask

    // k = 0 is the start edge; every wait is bounded by RUN_EDGES.
    task automatic capture(input int abort_edge, input int req_edge);
        int a;
        for (int i = 0; i < OUT_LEN; i++) got[i] = 'x;
        wr_cnt = 0; rd_cnt = 0; first_rd = -1; first_rd_addr = -1;
        ack_edge = -1; stray = 0; wr_after = 0;
        for (int k = 0; k < RUN_EDGES; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                busy_start = busy;
                ack_start  = ack;
            end
            if (mem_rd_en) begin
                rd_cnt++;
                if (first_rd < 0) begin
                    first_rd      = k / 2;
                    first_rd_addr = int'(mem_rd_addr);
                end
            end
            if (mem_wr_en) begin
                if (abort_edge >= 0 && k > abort_edge) begin
                    wr_after++;
                end else begin
                    wr_cnt++;
                    a = int'(mem_wr_addr) - OUT_BASE;
                    if (a >= 0 && a < OUT_LEN) got[a] = mem_wr_data;
                    else stray++;
                end
            end
            if (ack && ack_edge < 0) ack_edge = k;
            if (req_edge >= 0 && k == req_edge) req = 1'b1;
            if (req_edge >= 0 && k == req_edge + 2) req = 1'b0;
            if (k == abort_edge) begin
                init = 1'b1;
                #2 init = 1'b0;
            end
        end
        ack_end  = ack;
        busy_end = busy;
    endtask

    // Independent reference: clamp, pad, key stream and parity straight from the description.
    task automatic model(input logic [6:0] t, input logic [6:0] sd,
                         input logic [4:0] p_in, input logic [5:0] l_in);
        int p, l;
        logic [6:0] s;
        logic [6:0] c;
        logic [7:0] pt;
        p = (p_in < 5'd10) ? 10 : (p_in > 5'd26) ? 26 : int'(p_in);
        l = (l_in > 6'd52) ? 52 : int'(l_in);
        s = (sd == 7'h00) ? 7'h01 : sd;
        for (int i = 0; i < OUT_LEN; i++) begin
            pt = (i >= p && i < p + l) ? msg_mem[i - p] : 8'h20;
            c  = pt[6:0] ^ s;
            exp_out[i] = {^c, c};
            s = {s[5:0], ^(s & t)};
        end
    endtask

    function automatic int count_diffs();
        int n = 0;
        for (int i = 0; i < OUT_LEN; i++) if (got[i] !== exp_out[i]) n++;
        return n;
    endfunction

    task automatic check_full_run(input string tag);
        check({tag, "_bytes_vs_model"}, 32'(count_diffs()), 0);
        check({tag, "_wr_cnt"}, 32'(wr_cnt + stray), OUT_LEN);
        check({tag, "_ack_edge"}, 32'(ack_edge), ACK_EDGE);
        check({tag, "_busy_start"}, 32'(busy_start), 1);
        check({tag, "_ack_held"}, 32'(ack_end), 1);
    endtask

    initial begin
        string msg;
        int par_bad;
        logic [6:0] rt;
        logic [6:0] rs;

        init = 1'b1; req = 1'b0;
        tap_ptrn = '0; seed = '0; pre_len = '0; msg_len = '0;
`ifdef ERR_INJECT_EN
        inj_en = 1'b0; inj_idx = '0; inj_bit = '0;
`endif
        msg = "four score";
        for (int i = 0; i < 64; i++) msg_mem[i] = 8'(i * 37 + 129);
        for (int i = 0; i < 10; i++) msg_mem[i] = msg[i];

        vecs[0] = '{7'h60, 7'h01, 5'd10, 6'd0,  -1, 0,  8'h21, 8'hE1};
        vecs[1] = '{7'h60, 7'h00, 5'd10, 6'd0,  -1, 0,  8'h21, 8'hE1};
        vecs[2] = '{7'h60, 7'h01, 5'd3,  6'd10, 10, 10, 8'h21, 8'hE1};
        vecs[3] = '{7'h60, 7'h01, 5'd31, 6'd10, 26, 10, 8'h21, 8'hE1};
        vecs[4] = '{7'h60, 7'h01, 5'd12, 6'd63, 12, 52, 8'h21, 8'hE1};
        vecs[5] = '{7'h48, 7'h01, 5'd26, 6'd52, 26, 38, 8'h21, 8'hE4};
        vecs[6] = '{7'h60, 7'h55, 5'd10, 6'd52, 10, 52, 8'hF5, 8'h5F};

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rd_en", 32'(mem_rd_en), 0);
        check("rst_wr_en", 32'(mem_wr_en), 0);
        check("rst_rd_addr", 32'(mem_rd_addr), 0);
        check("rst_wr_addr", 32'(mem_wr_addr), 0);
        check("rst_wr_data", 32'(mem_wr_data), 0);
        init = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("no_start_unarmed", 32'(busy), 0);

        for (int v = 0; v < 7; v++) begin
            start_run(vecs[v].tap, vecs[v].seed, vecs[v].pre, vecs[v].len);
            // Vector 2 also raises req mid-run, which must be ignored.
            capture(-1, (v == 2) ? 50 : -1);
            model(vecs[v].tap, vecs[v].seed, vecs[v].pre, vecs[v].len);
            check_full_run($sformatf("v%0d", v));
            check($sformatf("v%0d_b0", v), 32'(got[0]), 32'(vecs[v].b0));
            check($sformatf("v%0d_b6", v), 32'(got[6]), 32'(vecs[v].b6));
            check($sformatf("v%0d_first_rd", v), 32'(first_rd), 32'(vecs[v].first_rd));
            check($sformatf("v%0d_rd_cnt", v), 32'(rd_cnt), 32'(vecs[v].rd_cnt));
        end

        // Plaintext message with a randomly chosen maximal-length tap and seed.
        rt = LFSR_PTRN[$urandom_range(0, 8)];
        rs = 7'($urandom);
        start_run(rt, rs, 5'd12, 6'd10);
        capture(-1, -1);
        model(rt, rs, 5'd12, 6'd10);
        check_full_run("msg");
        check("msg_rd_cnt", 32'(rd_cnt), 10);
        check("msg_first_rd", 32'(first_rd), 12);
        check("msg_first_rd_addr", 32'(first_rd_addr), 0);
        par_bad = 0;
        for (int i = 0; i < OUT_LEN; i++) if (got[i][7] !== ^got[i][6:0]) par_bad++;
        check("msg_parity", 32'(par_bad), 0);

        // Abort during byte 20, then restart from byte 0.
        start_run(7'h60, 7'h01, 5'd10, 6'd10);
        capture(41, -1);
        check("abort_wr_before", 32'(wr_cnt), 20);
        check("abort_wr_after", 32'(wr_after), 0);
        check("abort_ack", 32'(ack_edge), 32'(-1));
        check("abort_busy", 32'(busy_end), 0);
        start_run(7'h60, 7'h01, 5'd10, 6'd10);
        capture(-1, -1);
        model(7'h60, 7'h01, 5'd10, 6'd10);
        check_full_run("restart");
        check("restart_b0", 32'(got[0]), 'h21);

`ifdef ERR_INJECT_EN
        inj_en = 1'b1; inj_idx = 6'd30; inj_bit = 3'd7;
        start_run(7'h60, 7'h01, 5'd10, 6'd10);
        capture(-1, -1);
        model(7'h60, 7'h01, 5'd10, 6'd10);
        check("inj_diff_count", 32'(count_diffs()), 1);
        check("inj_byte30_xor", 32'(got[30] ^ exp_out[30]), 'h80);
        inj_en = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lfsr_encryptor.md
Name: lfsr_encryptor

Overview:
Hardware engine for Program 1 (message encryption). It is the producer whose output the Program 2/3 decrypt-and-flag logic consumes.
- Reads a plaintext ASCII message from data memory and prepends space padding.
- XORs each byte with a 7-bit maximal-length LFSR stream and writes parity into each byte's MSB.
- Writes the 64-byte ciphertext back to data memory.

Parameters:
MSG_BASE, 0, data-memory byte address of plaintext byte 0
OUT_BASE, 64, data-memory byte address of ciphertext byte 0
OUT_LEN, 64, number of ciphertext bytes produced per run
AW, 8, data-memory address width

Ports:
clk  in  1  system clock, rising edge
init  in  1  asynchronous active-high reset
req  in  1  request; high holds the engine idle, the high-to-low transition launches a run
ack  out  1  run complete; stays high until req is next high
busy  out  1  high while a run is in progress
tap_ptrn  in  7  LFSR feedback tap mask, one of the 9 maximal-length patterns
seed  in  7  LFSR initial state
pre_len  in  5  count of leading space bytes
msg_len  in  6  plaintext length in bytes
mem_rd_en  out  1  data-memory read strobe
mem_rd_addr  out  AW  read address
mem_rd_data  in  8  read data, valid exactly 1 cycle after mem_rd_en
mem_wr_en  out  1  data-memory write strobe
mem_wr_addr  out  AW  write address
mem_wr_data  out  8  write data

Behaviour:
- Reset (init high, asynchronous): state=IDLE; ack, busy, mem_rd_en, mem_wr_en = 0; addresses and data = 0; LFSR=0x01; byte index=0; armed=0.
- IDLE:
  - Sampling req=1 sets armed.
  - A cycle with armed=1 and req=0 is the start edge. On it, latch tap_ptrn, seed, pre_len and msg_len; go to FETCH; set busy=1; clear ack.
  - Seed 0 is replaced by 0x01.
  - pre_len is clamped to [10,26].
  - msg_len is clamped to ≤52.
- Per byte i (0..OUT_LEN-1), always exactly 2 cycles, FETCH then EMIT:
  - FETCH: if pre ≤ i < pre+len, drive mem_rd_en=1 with mem_rd_addr=MSG_BASE+i-pre. Otherwise mem_rd_en=0 and the plaintext byte is 0x20.
  - EMIT: c = p ^ {1'b0, lfsr}; c[7] = ^c[6:0] (even parity over bits 6:0). Drive mem_wr_en=1, mem_wr_addr=OUT_BASE+i, mem_wr_data=c.
  - LFSR step in EMIT: lfsr <= {lfsr[5:0], ^(lfsr & tap)}.
  - Plaintext bit 7 is ignored (XOR result bit 7 is overwritten by parity).
- After EMIT of byte OUT_LEN-1, go to DONE: ack=1, busy=0. ack rises at the 2·OUT_LEN+1-th rising edge after the start edge (129 by default).
- DONE holds ack until req is sampled high, then returns to IDLE with armed set.
- req going high mid-run is ignored; the run completes.
- init mid-run aborts immediately to the reset state; no further writes occur.
- Memory strobes are registered outputs, high for one cycle per access. Addresses wrap modulo 2^AW.

Optional Feature:
ERR_INJECT_EN
- Defined: adds input ports inj_en (1), inj_idx (6) and inj_bit (3). When inj_en=1 and i==inj_idx, EMIT writes c ^ (1<<inj_bit), with the flip applied after parity is computed. This produces a single corrupted byte for Program 3 flag checking.
- Undefined: the ports are absent and the output is always uncorrupted.

Decomposition:
- Package lfsr_pkg:
  - LFSR_PTRN[9] = 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B
  - SPACE=8'h20, PRE_MIN=10, PRE_MAX=26, MSG_MAX=52
  - state enum {IDLE, FETCH, EMIT, DONE}
- Sub-module lfsr7: 7-bit register with load, seed, tap and step-enable inputs; asynchronous init.

Test Plan:
- tap=0x60, seed=0x01, pre_len=10, msg_len=0 -> bytes 0..6 written as 0x21, 0x22, 0x24, 0x28, 0x30, 0x00, 0xE1; ack rises 129 edges after the start edge.
- seed=0x00, otherwise as above -> output identical to seed=0x01; no write has mem_wr_data with stuck-zero stream.
- pre_len=3 -> clamped to 10: no mem_rd_en during bytes 0..9, first read addr=MSG_BASE at i=10; pre_len=31 -> first read at i=26.
- msg "four score" (len 10), pre_len=12, random tap/seed -> each byte's bits 6:0 XOR the bench LFSR equal the padded text; bit 7 equals even parity of bits 6:0; exactly 10 reads.
- init pulsed at byte 20 -> mem_wr_en=0 thereafter, ack=0; a new req 1->0 restarts the run from byte 0.
- ERR_INJECT_EN, inj_idx=30, inj_bit=7 -> only byte 30 differs from the golden output, by exactly its MSB.
